// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 timing constants and 320x200 image geometry
//                shared by the timing generator and the scanout controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  typedef logic [9:0] cnt_t;

  // Horizontal timing, in pixel clocks
  localparam cnt_t H_VISIBLE    = 10'd640;
  localparam cnt_t H_FRONT      = 10'd16;
  localparam cnt_t H_SYNC       = 10'd96;
  localparam cnt_t H_BACK       = 10'd48;
  localparam cnt_t H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam cnt_t H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;

  // Vertical timing, in lines
  localparam cnt_t V_VISIBLE    = 10'd480;
  localparam cnt_t V_FRONT      = 10'd10;
  localparam cnt_t V_SYNC       = 10'd2;
  localparam cnt_t V_BACK       = 10'd33;
  localparam cnt_t V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam cnt_t V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Image geometry: 320x200 at 1bpp, every source pixel doubled both ways
  localparam cnt_t IMG_W_BYTES  = 10'd40;
  localparam cnt_t IMG_ROWS     = 10'd200;
  localparam cnt_t BORDER_TOP   = 10'd40;
  localparam cnt_t IMG_LAST_ROW = BORDER_TOP + IMG_ROWS + IMG_ROWS - 10'd1;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Horizontal/vertical pixel counters and registered active-low
//                syncs plus display-enable, one clock behind the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  output cnt_t hcnt,
  output cnt_t vcnt,
  output logic hsync,
  output logic vsync,
  output logic de
);

  // Free-running raster counters; vcnt steps (and wraps) as hcnt wraps
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOTAL - 10'd1) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Sync and display-enable decoded from the counters, registered once
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
    end else begin
      hsync <= !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
      vsync <= !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));
      de    <= (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_scanout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout_ctrl
//  Description : Monochrome 320x200 framebuffer scanout onto a 640x480 raster.
//                Fetches one byte per 16 screen pixels from a shared BRAM port
//                and shifts it out MSB first, each bit shown for two clocks.
//                Optional macro VGA_SCANOUT_VBLANK_IRQ_EN adds O_vblank_irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout_ctrl
  import vga_timing_pkg::*;
#(
  parameter int ADDRBITS = 13,
  parameter int BASEADDR = 0
) (
  input  logic                I_clk,
  input  logic                I_reset_n,
  input  logic                I_enable,
  output logic                O_vga_req,
  output logic [ADDRBITS-1:0] O_vga_adr,
  input  logic [7:0]          I_vga_dat,
  output logic                O_hsync,
  output logic                O_vsync,
  output logic                O_de,
  output logic                O_pixel
`ifdef VGA_SCANOUT_VBLANK_IRQ_EN
  ,
  output logic                O_vblank_irq
`endif
);

  // A fetch is decided one clock before the request is visible, so the
  // decision points sit 3 clocks before the consuming slot: hcnt%16==13 for
  // in-line slots, and hcnt=797 for the next line's column 0 prefetch.
  localparam cnt_t INLINE_DECIDE_LIMIT = H_VISIBLE - 10'd3;
  localparam cnt_t PREFETCH_DECIDE     = H_TOTAL - 10'd3;
  localparam logic [ADDRBITS-1:0] BASE_ADR = ADDRBITS'(BASEADDR);

  cnt_t                hcnt;
  cnt_t                vcnt;
  logic                en_frame;
  logic [ADDRBITS-1:0] line_base;
  logic                req_d;
  logic [7:0]          hold;
  logic [7:0]          shifter;
  logic                frame_start;
  logic                in_img_row;
  logic                prefetch_row;
  logic                fetch_inline;
  logic                fetch_pre;
  logic [5:0]          fetch_col;
  logic                pix_bit;

  vga_timing_gen u_timing (
    .clk     (I_clk),
    .reset_n (I_reset_n),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .hsync   (O_hsync),
    .vsync   (O_vsync),
    .de      (O_de)
  );

  // Fetch scheduling and pixel-bit selection decoded from the raster position
  always_comb begin
    frame_start  = (hcnt == '0) && (vcnt == '0);
    in_img_row   = (vcnt >= BORDER_TOP) && (vcnt <= IMG_LAST_ROW);
    prefetch_row = (vcnt >= BORDER_TOP - 10'd1) && (vcnt <= IMG_LAST_ROW - 10'd1);
    fetch_inline = en_frame && in_img_row && (hcnt[3:0] == 4'd13) &&
                   (hcnt < INLINE_DECIDE_LIMIT);
    fetch_pre    = en_frame && prefetch_row && (hcnt == PREFETCH_DECIDE);
    fetch_col    = fetch_pre ? 6'd0 : hcnt[9:4] + 6'd1;
    // At slot start the shifter has not been loaded yet, so the first bit
    // comes straight from the holding register.
    pix_bit      = (hcnt[3:0] == 4'd0) ? hold[7] : shifter[7];
  end

  // Enable is sampled only at frame start so a frame is never split
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      en_frame <= 1'b0;
    end else if (frame_start) begin
      en_frame <= I_enable;
    end
  end

  // Line base: start of the current source row, advanced after each odd row
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      line_base <= BASE_ADR;
    end else if (frame_start) begin
      line_base <= BASE_ADR;
    end else if (in_img_row && vcnt[0] && (hcnt == H_VISIBLE)) begin
      line_base <= line_base + ADDRBITS'(IMG_W_BYTES);
    end
  end

  // Read request pulse and address; the address holds its value when idle
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      O_vga_req <= 1'b0;
      O_vga_adr <= BASE_ADR;
      req_d     <= 1'b0;
    end else begin
      O_vga_req <= fetch_inline || fetch_pre;
      req_d     <= O_vga_req;
      if (fetch_inline || fetch_pre) begin
        O_vga_adr <= line_base + ADDRBITS'(fetch_col);
      end
    end
  end

  // Capture returning data; a fetch in flight at reset is dropped via req_d
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      hold <= '0;
    end else if (req_d) begin
      hold <= I_vga_dat;
    end
  end

  // Pixel shifter: load at slot start, advance one bit every second clock
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      shifter <= '0;
    end else if (hcnt[3:0] == 4'd0) begin
      shifter <= hold;
    end else if (hcnt[0]) begin
      shifter <= {shifter[6:0], 1'b0};
    end
  end

  // Output pixel, registered to line up with the registered syncs and DE
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      O_pixel <= 1'b0;
    end else begin
      O_pixel <= en_frame && in_img_row && (hcnt < H_VISIBLE) && pix_bit;
    end
  end

`ifdef VGA_SCANOUT_VBLANK_IRQ_EN
  // One-clock vertical blanking pulse, aligned with the other outputs
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      O_vblank_irq <= 1'b0;
    end else begin
      O_vblank_irq <= (hcnt == '0) && (vcnt == V_VISIBLE);
    end
  end
`endif

endmodule
`default_nettype wire
